// File: rtl/vol_pkg.sv
// Shared types and helpers for the pedalboard volume step controller.
//   panel_state_t : panel button sequencer states
//   dir_t         : step direction
//   therm8()      : level (0..8) to 8-bit thermometer word, ones filled from the LSB
package vol_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STEP,
      HOLD,
      REPEAT
   } panel_state_t;

   typedef enum logic {
      DIR_DOWN,
      DIR_UP
   } dir_t;

   localparam int LEVEL_W = 4;
   localparam int DATA_W  = 8;

   // Bit i is set when level is above i, so level=3 gives 8'b0000_0111.
   function automatic logic [DATA_W-1:0] therm8(input logic [LEVEL_W-1:0] level);
      logic [DATA_W-1:0] t;
      t = '0;
      for (int i = 0; i < DATA_W; i++) begin
         t[i] = (LEVEL_W'(i) < level);
      end
      return t;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Panel button conditioner: a two-flop synchronizer followed by a stable-sample
// filter. The output follows the button only after DEBOUNCE_CYCLES consecutive
// synchronized samples that all disagree with the current output.
// Ports:
//   i_clk    in  system clock
//   i_rst_n  in  asynchronous active-low reset (output returns to "released")
//   i_raw    in  raw asynchronous button level
//   o_level  out debounced button level, 1 = pressed
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 50_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;

   // The counter tracks how many samples in a row have disagreed with the
   // accepted level; any agreeing sample starts the run over, so short
   // bounces never reach the threshold.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_level = r_stable;

endmodule

// File: rtl/volume_step_controller.sv
// Pedalboard volume register sequencer. Debounces the panel up/down buttons,
// adds hold-to-repeat, arbitrates panel steps against a remote step requester
// and keeps a saturating volume level with a registered thermometer output.
// Ports:
//   Clk       in   system clock
//   Reset     in   asynchronous active-low reset
//   Vol_up    in   raw panel up button
//   Vol_down  in   raw panel down button
//   Rmt_req   in   remote step request, held until Rmt_ack
//   Rmt_dir   in   remote direction, 1 = up, 0 = down
//   Rmt_ack   out  one-cycle pulse, remote request consumed
//   Level     out  current volume level (0..MAX_LEVEL)
//   Data      out  thermometer of Level, one cycle behind Level
//   Sat       out  one-cycle pulse, a step at a limit was dropped
module volume_step_controller
   import vol_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_RATE     = 5_000_000,
   parameter int MAX_LEVEL       = 8,
   parameter int DEFAULT_LEVEL   = 4
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Vol_up,
   input  logic               Vol_down,
   input  logic               Rmt_req,
   input  logic               Rmt_dir,
   output logic               Rmt_ack,
   output logic [LEVEL_W-1:0] Level,
   output logic [DATA_W-1:0]  Data,
   output logic               Sat
);

   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
   localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0] LVL_DEF = LEVEL_W'(DEFAULT_LEVEL);

   logic w_up;
   logic w_down;
   logic w_upOnly;
   logic w_downOnly;
   logic w_held;
   logic w_expire;
   logic w_panelStep;
   logic w_rmtGrant;
   logic w_stepValid;
   logic w_stepUp;

   panel_state_t r_state;
   panel_state_t w_nextState;
   dir_t         r_dir;
   dir_t         w_nextDir;

   logic [HOLD_W-1:0]  r_holdCnt;
   logic               r_rmtBlock;
   logic [LEVEL_W-1:0] r_level;
   logic [DATA_W-1:0]  r_data;
   logic               r_ack;
   logic               r_sat;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debUp (
      .i_clk   (Clk),
      .i_rst_n (Reset),
      .i_raw   (Vol_up),
      .o_level (w_up)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debDown (
      .i_clk   (Clk),
      .i_rst_n (Reset),
      .i_raw   (Vol_down),
      .o_level (w_down)
   );

   // Both buttons down counts as no button. "Held" means the latched direction
   // is still the only button pressed, so a direction change reads as a release.
   assign w_upOnly   = w_up & ~w_down;
   assign w_downOnly = w_down & ~w_up;
   assign w_held     = (r_dir == DIR_UP) ? w_upOnly : w_downOnly;
   assign w_expire   = (r_holdCnt == HOLD_W'(1));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= IDLE;
         r_dir   <= DIR_UP;
      end else begin
         r_state <= w_nextState;
         r_dir   <= w_nextDir;
      end
   end

   // Release is tested before expiry so a button let go on the expiry cycle
   // produces no extra step.
   always_comb begin
      w_nextState = r_state;
      w_nextDir   = r_dir;
      w_panelStep = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_upOnly || w_downOnly) begin
               w_nextState = STEP;
               w_nextDir   = w_upOnly ? DIR_UP : DIR_DOWN;
            end
         end
         STEP: begin
            w_panelStep = 1'b1;
            w_nextState = HOLD;
         end
         HOLD, REPEAT: begin
            if (!w_held) begin
               w_nextState = IDLE;
            end else if (w_expire) begin
               w_panelStep = 1'b1;
               w_nextState = REPEAT;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Counts down to 1; the step fires on the cycle the count reads 1, so a
   // load of N puts the next step N cycles after the loading cycle.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_holdCnt <= '0;
      end else if (r_state == STEP) begin
         r_holdCnt <= HOLD_W'(REPEAT_DELAY);
      end else if ((r_state == HOLD || r_state == REPEAT) && w_held) begin
         r_holdCnt <= w_expire ? HOLD_W'(REPEAT_RATE) : (r_holdCnt - HOLD_W'(1));
      end
   end

   // A granted request stays blocked until the requester drops Rmt_req.
   assign w_rmtGrant  = Rmt_req && !r_rmtBlock && !w_panelStep;
   assign w_stepValid = w_panelStep || w_rmtGrant;
   assign w_stepUp    = w_panelStep ? (r_dir == DIR_UP) : Rmt_dir;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_rmtBlock <= 1'b0;
      end else if (w_rmtGrant) begin
         r_rmtBlock <= 1'b1;
      end else if (!Rmt_req) begin
         r_rmtBlock <= 1'b0;
      end
   end

   // Ack, Sat and the new Level all appear on the same edge; Data trails Level.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_level <= LVL_DEF;
         r_data  <= therm8(LVL_DEF);
         r_ack   <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         r_ack  <= w_rmtGrant;
         r_sat  <= 1'b0;
         r_data <= therm8(r_level);
         if (w_stepValid) begin
            if (w_stepUp) begin
               if (r_level == LVL_MAX) begin
                  r_sat <= 1'b1;
               end else begin
                  r_level <= r_level + LEVEL_W'(1);
               end
            end else begin
               if (r_level == '0) begin
                  r_sat <= 1'b1;
               end else begin
                  r_level <= r_level - LEVEL_W'(1);
               end
            end
         end
      end
   end

   assign Rmt_ack = r_ack;
   assign Level   = r_level;
   assign Data    = r_data;
   assign Sat     = r_sat;

endmodule

// File: tb/tb_volume_step_controller.sv
// Bench for volume_step_controller with short debounce/repeat timing.
// A behavioural model advances once per rising edge and predicts Level, Data,
// Rmt_ack and Sat; outputs are compared on the falling edge.
module tb_volume_step_controller;

   localparam int DEB  = 4;
   localparam int RD   = 20;
   localparam int RR   = 5;
   localparam int MAXL = 8;
   localparam int DEFL = 4;

   logic       clk;
   logic       rst_n;
   logic       volUp;
   logic       volDown;
   logic       rmtReq;
   logic       rmtDir;
   logic       rmtAck;
   logic [3:0] level;
   logic [7:0] data;
   logic       sat;

   int total = 0;
   int bad   = 0;

   // model state
   bit       mUp1, mUp2, mDn1, mDn2;
   bit       mDebUp, mDebDn;
   bit       histUp[$];
   bit       histDn[$];
   int       mMode;
   int       mElapsed;
   bit       mDir;
   bit       mBlocked;
   int       mLevel;
   logic [7:0] mData;
   bit       mAck;
   bit       mSat;

   volume_step_controller #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR),
      .MAX_LEVEL       (MAXL),
      .DEFAULT_LEVEL   (DEFL)
   ) dut (
      .Clk      (clk),
      .Reset    (rst_n),
      .Vol_up   (volUp),
      .Vol_down (volDown),
      .Rmt_req  (rmtReq),
      .Rmt_dir  (rmtDir),
      .Rmt_ack  (rmtAck),
      .Level    (level),
      .Data     (data),
      .Sat      (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic bit runComplete(input bit hist[$], input bit target);
      if (hist.size() < DEB) return 1'b0;
      foreach (hist[k]) begin
         if (hist[k] != target) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic modelReset();
      mUp1 = 0; mUp2 = 0; mDn1 = 0; mDn2 = 0;
      mDebUp = 0; mDebDn = 0;
      histUp.delete();
      histDn.delete();
      mMode = 0; mElapsed = 0; mDir = 1; mBlocked = 0;
      mLevel = DEFL;
      mData = 8'((1 << DEFL) - 1);
      mAck = 0; mSat = 0;
   endtask

   // Mode 0 = waiting for a press, 1 = press accepted (step this cycle),
   // 2 = held; mElapsed counts cycles since the first step.
   task automatic modelEdge();
      bit active, panel, grant, goUp;
      if (!rst_n) begin
         modelReset();
         return;
      end
      panel  = 0;
      active = mDebUp ^ mDebDn;
      case (mMode)
         0: begin
            if (active) begin
               mMode = 1;
               mDir  = mDebUp;
            end
         end
         1: begin
            panel    = 1;
            mMode    = 2;
            mElapsed = 0;
         end
         default: begin
            mElapsed++;
            if (!(active && (mDebUp == mDir))) mMode = 0;
            else if (mElapsed >= RD && ((mElapsed - RD) % RR) == 0) panel = 1;
         end
      endcase
      grant = rmtReq && !mBlocked && !panel;
      if (grant) mBlocked = 1;
      else if (!rmtReq) mBlocked = 0;
      mData = 8'((1 << mLevel) - 1);
      mAck  = grant;
      mSat  = 0;
      if (panel || grant) begin
         goUp = panel ? mDir : rmtDir;
         if (goUp) begin
            if (mLevel == MAXL) mSat = 1;
            else mLevel++;
         end else begin
            if (mLevel == 0) mSat = 1;
            else mLevel--;
         end
      end
      histUp.push_back(mUp2);
      if (histUp.size() > DEB) void'(histUp.pop_front());
      histDn.push_back(mDn2);
      if (histDn.size() > DEB) void'(histDn.pop_front());
      if (runComplete(histUp, !mDebUp)) mDebUp = !mDebUp;
      if (runComplete(histDn, !mDebDn)) mDebDn = !mDebDn;
      mUp2 = mUp1; mUp1 = volUp;
      mDn2 = mDn1; mDn1 = volDown;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic stepCycle(input string tag);
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkOutput({tag, "_level"}, {4'b0, level}, 8'(mLevel));
      checkOutput({tag, "_data"}, data, mData);
      checkOutput({tag, "_ack"}, {7'b0, rmtAck}, {7'b0, mAck});
      checkOutput({tag, "_sat"}, {7'b0, sat}, {7'b0, mSat});
   endtask

   task automatic applyStimulus(input logic up, input logic down, input logic req, input logic dir);
      volUp   = up;
      volDown = down;
      rmtReq  = req;
      rmtDir  = dir;
   endtask

   task automatic resetPulse();
      applyStimulus(0, 0, 0, 0);
      rst_n = 1'b0;
      modelReset();
      stepCycle("rstp");
      rst_n = 1'b1;
   endtask

   task automatic remoteStep(input logic dir, input string tag, output logic satAtAck);
      bit got;
      got = 0;
      satAtAck = 0;
      applyStimulus(0, 0, 1, dir);
      for (int i = 0; i < 30 && !got; i++) begin
         stepCycle(tag);
         if (rmtAck) begin
            got = 1;
            satAtAck = sat;
         end
      end
      checkOutput({tag, "_acked"}, {7'b0, got}, 8'd1);
      applyStimulus(0, 0, 0, dir);
      stepCycle(tag);
   endtask

   initial begin
      int   satCount;
      int   ackCount;
      bit   acked;
      logic satSeen;

      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0);
      modelReset();

      // 1. reset
      repeat (3) stepCycle("reset");
      checkOutput("reset_level", {4'b0, level}, 8'd4);
      checkOutput("reset_data", data, 8'h0F);
      checkOutput("reset_ack", {7'b0, rmtAck}, 8'd0);
      rst_n = 1'b1;
      repeat (3) stepCycle("post_reset");

      // 2. glitch then a short press
      applyStimulus(1, 0, 0, 0);
      repeat (3) stepCycle("glitch");
      applyStimulus(0, 0, 0, 0);
      repeat (10) stepCycle("glitch_idle");
      checkOutput("glitch_level", {4'b0, level}, 8'd4);
      applyStimulus(1, 0, 0, 0);
      repeat (10) stepCycle("press");
      applyStimulus(0, 0, 0, 0);
      repeat (15) stepCycle("press_rel");
      checkOutput("press_level", {4'b0, level}, 8'd5);
      checkOutput("press_data", data, 8'h1F);

      // 3. long hold with auto-repeat up to saturation
      resetPulse();
      satCount = 0;
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         stepCycle("repeat");
         satCount += int'(sat);
      end
      applyStimulus(0, 0, 0, 0);
      for (int i = 0; i < 15; i++) begin
         stepCycle("repeat_rel");
         satCount += int'(sat);
      end
      checkOutput("repeat_level", {4'b0, level}, 8'd8);
      checkOutput("repeat_data", data, 8'hFF);
      checkOutput("repeat_satcount", 8'(satCount), 8'd1);

      // 4. remote down, request held past ack
      resetPulse();
      ackCount = 0;
      applyStimulus(0, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         stepCycle("remote");
         ackCount += int'(rmtAck);
      end
      applyStimulus(0, 0, 0, 0);
      repeat (3) stepCycle("remote_idle");
      checkOutput("remote_ackcount", 8'(ackCount), 8'd1);
      checkOutput("remote_level", {4'b0, level}, 8'd3);

      // 5. panel step and remote request in the same cycle
      resetPulse();
      applyStimulus(1, 0, 0, 0);
      repeat (7) stepCycle("collide_pre");
      applyStimulus(1, 0, 1, 0);
      stepCycle("collide_panel");
      checkOutput("collide_panel_level", {4'b0, level}, 8'd5);
      checkOutput("collide_panel_ack", {7'b0, rmtAck}, 8'd0);
      stepCycle("collide_remote");
      checkOutput("collide_remote_ack", {7'b0, rmtAck}, 8'd1);
      checkOutput("collide_remote_level", {4'b0, level}, 8'd4);
      applyStimulus(0, 0, 0, 0);
      repeat (15) stepCycle("collide_post");
      checkOutput("collide_net_level", {4'b0, level}, 8'd4);

      // 6. both buttons, then limits via remote
      applyStimulus(1, 1, 0, 0);
      repeat (10) stepCycle("both");
      applyStimulus(0, 0, 0, 0);
      repeat (10) stepCycle("both_rel");
      checkOutput("both_level", {4'b0, level}, 8'd4);
      for (int i = 0; i < 4; i++) remoteStep(0, "to_zero", satSeen);
      checkOutput("zero_level", {4'b0, level}, 8'd0);
      remoteStep(0, "below_zero", satSeen);
      checkOutput("below_zero_sat", {7'b0, satSeen}, 8'd1);
      checkOutput("below_zero_level", {4'b0, level}, 8'd0);
      for (int i = 0; i < 8; i++) remoteStep(1, "to_max", satSeen);
      checkOutput("max_level", {4'b0, level}, 8'd8);
      remoteStep(1, "above_max", satSeen);
      checkOutput("above_max_sat", {7'b0, satSeen}, 8'd1);
      checkOutput("above_max_level", {4'b0, level}, 8'd8);

      // 7. asynchronous reset in the middle of a hold
      resetPulse();
      applyStimulus(1, 0, 0, 0);
      repeat (30) stepCycle("midhold");
      checkOutput("midhold_level", {4'b0, level}, 8'd6);
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("async_level", {4'b0, level}, 8'd4);
      checkOutput("async_data", data, 8'h0F);
      checkOutput("async_ack", {7'b0, rmtAck}, 8'd0);
      checkOutput("async_sat", {7'b0, sat}, 8'd0);
      applyStimulus(0, 0, 0, 0);
      repeat (2) stepCycle("async_hold");
      rst_n = 1'b1;
      repeat (20) stepCycle("async_after");
      checkOutput("async_after_level", {4'b0, level}, 8'd4);

      // 8. random buttons and remote traffic
      resetPulse();
      acked = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 39) == 0) volUp = ~volUp;
         if ($urandom_range(0, 59) == 0) volDown = ~volDown;
         if (rmtReq) begin
            if (acked && $urandom_range(0, 1) == 0) begin
               rmtReq = 1'b0;
               acked  = 0;
            end
         end else if ($urandom_range(0, 9) == 0) begin
            rmtReq = 1'b1;
            rmtDir = 1'($urandom_range(0, 1));
         end
         stepCycle("rand");
         if (rmtAck) acked = 1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
